// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants and state encoding for the sort chain
//
// Purpose: one place for the data width, the chain length and the FSM state
// type so the feeder, the insertion cells and the collector agree.
// Ports: none (package).
package sort_pkg;

  localparam int DATA_W  = 32;
  // Number of insertion cells in the chain; one word per cell per transaction.
  localparam int N_CELLS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sort_collect_if.sv
// rtl/sort_collect_if.sv - block control and FIFO handshake bundle of sort_collect
//
// Purpose: groups ap_* block control, the input FIFO read side, the output
// FIFO write side and the order-check flag.
// Modports: slave = the collector, master = whoever drives it.
interface sort_collect_if;
  import sort_pkg::*;

  logic              ap_start;
  logic              ap_done;
  logic              ap_continue;
  logic              ap_idle;
  logic              ap_ready;
  logic [DATA_W-1:0] in_V_dout;
  logic              in_V_empty_n;
  logic              in_V_read;
  logic [DATA_W-1:0] out_V_din;
  logic              out_V_full_n;
  logic              out_V_write;
  logic              sort_err;

  modport slave (
    input  ap_start, ap_continue, in_V_dout, in_V_empty_n, out_V_full_n,
    output ap_done, ap_idle, ap_ready, in_V_read, out_V_din, out_V_write, sort_err
  );

  modport master (
    output ap_start, ap_continue, in_V_dout, in_V_empty_n, out_V_full_n,
    input  ap_done, ap_idle, ap_ready, in_V_read, out_V_din, out_V_write, sort_err
  );

endinterface

// File: rtl/sort_collect_buf.sv
// rtl/sort_collect_buf.sv - word buffer for sort_collect
//
// Purpose: N_WORDS x DATA_W register array, contents never reset.
// Ports: clk_i, we_i/waddr_i/wdata_i (synchronous write),
//        raddr_i/rdata_o (combinational read).
module sort_collect_buf
  import sort_pkg::*;
#(
  parameter int N_WORDS = N_CELLS,
  parameter int AW      = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [N_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sort_collect.sv
// rtl/sort_collect.sv - drain stage: buffers N_WORDS words and emits them reversed
//
// Purpose: collects one transaction from the last sort cell (non-increasing
// order) and writes it back out in reverse, giving an ascending stream.
// Ports: ap_clk, ap_rst_n (sync, active low), bus (sort_collect_if.slave).
// Optional: define SORT_COLLECT_CHECK_EN to build the input order checker
// driving sort_err; otherwise sort_err is tied low.
module sort_collect
  import sort_pkg::*;
#(
  parameter int N_WORDS = N_CELLS,
  parameter int IDX_W   = 8
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  sort_collect_if.slave bus
);

  localparam int AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             pop;
  logic             push;
  logic             last_pop;

  // Handshakes are masked during reset so nothing is popped or pushed
  // on the edge that abandons a transaction.
  assign pop      = ap_rst_n && (state_q == FILL)  && bus.in_V_empty_n;
  assign push     = ap_rst_n && (state_q == DRAIN) && bus.out_V_full_n;
  assign last_pop = pop && (wr_idx_q == LAST_IDX);

  assign bus.in_V_read   = pop;
  assign bus.out_V_write = push;
  assign bus.ap_ready    = last_pop;
  assign bus.ap_done     = ap_rst_n && (state_q == DONE);
  assign bus.ap_idle     = (state_q == IDLE) && !bus.ap_start;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.ap_start) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
          end
        end
        FILL: begin
          if (pop) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (last_pop) begin
              rd_idx_q <= LAST_IDX;
              state_q  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (push) begin
            rd_idx_q <= rd_idx_q - IDX_W'(1);
            if (rd_idx_q == '0) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.ap_continue) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sort_collect_buf #(
    .N_WORDS (N_WORDS),
    .AW      (AW)
  ) u_buf (
    .clk_i   (ap_clk),
    .we_i    (pop),
    .waddr_i (wr_idx_q[AW-1:0]),
    .wdata_i (bus.in_V_dout),
    .raddr_i (rd_idx_q[AW-1:0]),
    .rdata_o (bus.out_V_din)
  );

`ifdef SORT_COLLECT_CHECK_EN
  logic [DATA_W-1:0] prev_q;
  logic              sort_err_q;

  // The first word of a transaction has no predecessor, so it only loads prev_q.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      sort_err_q <= 1'b0;
    end else if ((state_q == IDLE) && bus.ap_start) begin
      sort_err_q <= 1'b0;
    end else if (pop) begin
      prev_q <= bus.in_V_dout;
      if ((wr_idx_q != '0) && ($signed(bus.in_V_dout) > $signed(prev_q))) begin
        sort_err_q <= 1'b1;
      end
    end
  end

  assign bus.sort_err = sort_err_q;
`else
  assign bus.sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_collect.sv
// tb/tb_sort_collect.sv - scoreboard bench for sort_collect
module tb_sort_collect;

  logic clk;
  logic rst_n;

  sort_collect_if bus ();

  sort_collect #(.N_WORDS(8), .IDX_W(8)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] in_q  [$];
  logic [31:0] exp_q [$];

  int pop_cnt   = 0;
  int push_cnt  = 0;
  int ready_cnt = 0;
  int pop_base  = 0;

  bit empty_toggle = 1'b0;
  bit empty_phase  = 1'b1;
  bit stall_arm    = 1'b0;
  int stall_at     = 0;
  int stall_left   = 0;
  bit have_held    = 1'b0;
  logic [31:0] held_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // FIFO models: inputs change on the falling edge, handshakes are sampled
  // 1 ns later, i.e. the values the next rising edge will act on.
  always begin
    @(negedge clk);
    if (empty_toggle) empty_phase = ~empty_phase;
    else              empty_phase = 1'b1;
    bus.in_V_empty_n = (in_q.size() != 0) && empty_phase;
    bus.in_V_dout    = (in_q.size() != 0) ? in_q[0] : 32'h0;
    if (stall_arm && push_cnt == stall_at) begin
      stall_left = 3;
      stall_arm  = 1'b0;
    end
    bus.out_V_full_n = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    #1;
    if (!bus.out_V_full_n) begin
      if (have_held) check("stall_din", bus.out_V_din, held_din);
      held_din  = bus.out_V_din;
      have_held = 1'b1;
    end else begin
      have_held = 1'b0;
    end
    if (bus.in_V_read && bus.out_V_write) check("rd_wr_excl", 32'd1, 32'd0 + (bus.in_V_read ^ bus.out_V_write));
    if (bus.in_V_read) begin
      check("rd_nonempty", bus.in_V_empty_n, 1);
      if (bus.in_V_empty_n) begin
        void'(in_q.pop_front());
        pop_cnt++;
      end
    end
    if (bus.ap_ready) begin
      ready_cnt++;
      check("ready_pop", pop_cnt - pop_base, 8);
    end
    if (bus.out_V_write) begin
      check("push_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("dout", bus.out_V_din, exp_q.pop_front());
      push_cnt++;
    end
  end

  task automatic start_txn(input logic [31:0] w[8], input int exp_lat, input bit preloaded);
    bit e_err = 1'b0;
    int lat;
    int rdy0;
    if (!preloaded) for (int i = 0; i < 8; i++) in_q.push_back(w[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SORT_COLLECT_CHECK_EN
    for (int i = 1; i < 8; i++) if ($signed(w[i]) > $signed(w[i-1])) e_err = 1'b1;
`endif
    rdy0     = ready_cnt;
    pop_base = pop_cnt;
    bus.ap_start = 1'b1;
    @(posedge clk);
    lat = 1;
    #2;
    bus.ap_start = 1'b0;
    check("err_clr", bus.sort_err, 0);
    while (!bus.ap_done && lat < 600) begin
      @(posedge clk);
      lat++;
      #2;
    end
    check("done_seen", bus.ap_done, 1);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check("sort_err", bus.sort_err, e_err);
    check("ready_pulses", ready_cnt - rdy0, 1);
    check("out_left", exp_q.size(), 0);
    check("in_left", in_q.size(), 0);
  endtask

  task automatic end_txn(input int hold);
    int p0 = pop_cnt;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #2;
      check("done_hold", bus.ap_done, 1);
    end
    check("no_read_done", pop_cnt, p0);
    bus.ap_continue = 1'b1;
    @(posedge clk);
    #2;
    bus.ap_continue = 1'b0;
    check("idle_after", bus.ap_idle, 1);
    check("done_clr", bus.ap_done, 0);
  endtask

  logic [31:0] w_basic [8] = '{70, 60, 50, 40, 30, 20, 10, 0};
  logic [31:0] w_sign  [8] = '{32'h7FFFFFFF, 5, 0, 32'hFFFFFFFF, 32'h80000000,
                               32'h80000000, 32'h80000000, 32'h80000000};
  logic [31:0] w_bp    [8] = '{100, 90, 90, -3, -4, -50, -60, -1000};
  logic [31:0] w_a     [8] = '{8, 7, 6, 5, 4, 3, 2, 1};
  logic [31:0] w_b     [8] = '{500, 400, 300, 200, 100, 0, -100, -200};
  logic [31:0] w_bad   [8] = '{9, 8, 7, 8, 5, 4, 3, 2};

  initial begin
    int guard;
    bus.ap_start     = 1'b0;
    bus.ap_continue  = 1'b0;
    bus.in_V_dout    = 32'h0;
    bus.in_V_empty_n = 1'b0;
    bus.out_V_full_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_idle", bus.ap_idle, 1);
    check("rst_done", bus.ap_done, 0);
    check("rst_ready", bus.ap_ready, 0);
    check("rst_read", bus.in_V_read, 0);
    check("rst_write", bus.out_V_write, 0);
    check("rst_err", bus.sort_err, 0);

    start_txn(w_basic, 17, 1'b0);
    end_txn(0);

    start_txn(w_sign, 17, 1'b0);
    end_txn(0);

    empty_toggle = 1'b1;
    stall_at  = push_cnt + 3;
    stall_arm = 1'b1;
    start_txn(w_bp, 0, 1'b0);
    end_txn(0);
    empty_toggle = 1'b0;

    start_txn(w_a, 17, 1'b0);
    for (int i = 0; i < 8; i++) in_q.push_back(w_b[i]);
    end_txn(5);
    start_txn(w_b, 17, 1'b1);
    end_txn(0);

    for (int i = 0; i < 8; i++) in_q.push_back(w_a[i]);
    pop_base = pop_cnt;
    bus.ap_start = 1'b1;
    @(posedge clk);
    #2;
    bus.ap_start = 1'b0;
    guard = 0;
    while ((pop_cnt - pop_base) < 4 && guard < 100) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("pops_before_rst", pop_cnt - pop_base, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    in_q.delete();
    check("midrst_idle", bus.ap_idle, 1);
    check("midrst_read", bus.in_V_read, 0);
    check("midrst_write", bus.out_V_write, 0);
    check("midrst_done", bus.ap_done, 0);
    repeat (2) @(posedge clk);
    #2;
    start_txn(w_basic, 17, 1'b0);
    end_txn(0);

    start_txn(w_bad, 17, 1'b0);
    end_txn(0);
    start_txn(w_b, 17, 1'b0);
    end_txn(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sort_collect.md
Name: sort_collect

Overview:
- Drain stage directly downstream of the last insertion-sort cell in the FIFO dataflow chain.
- Per transaction: reads exactly N_WORDS signed 32-bit words from the cell chain's output FIFO into a local buffer, then writes them to the result FIFO in reverse arrival order.
- The chain emits non-increasing order, so the result stream is ascending.
- Block-level control follows the chained start/done/continue protocol used by the cells.

Parameters:
- N_WORDS, 8, words per transaction (2..256).
- IDX_W, 8, index/counter width; must satisfy 2^IDX_W >= N_WORDS.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- ap_start  in  1  transaction request.
- ap_done  out  1  transaction complete.
- ap_continue  in  1  downstream acknowledges done.
- ap_idle  out  1  block idle.
- ap_ready  out  1  last input word accepted.
- in_V_dout  in  32  input FIFO data (signed).
- in_V_empty_n  in  1  input FIFO not empty.
- in_V_read  out  1  input FIFO pop.
- out_V_din  out  32  output FIFO data.
- out_V_full_n  in  1  output FIFO not full.
- out_V_write  out  1  output FIFO push.
- sort_err  out  1  order violation flag (see Optional Feature).

Behaviour:
- Reset: ap_rst_n=0 at a rising edge forces state to IDLE and clears wr_idx, rd_idx and sort_err.
  - While in reset/IDLE: ap_done=0, ap_ready=0, in_V_read=0, out_V_write=0.
  - out_V_din is don't-care while out_V_write=0; drive the buffer mux output.
  - Buffer contents are not reset.
  - Reset mid-FILL or mid-DRAIN abandons the transaction. No partial restart. Words already popped are lost.
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - ap_idle = ap_start==0 (combinational).
  - ap_start=1 -> FILL, wr_idx<=0.
- FILL:
  - in_V_read = in_V_empty_n (combinational).
  - On a pop: buf[wr_idx]<=in_V_dout, wr_idx++.
  - On the pop with wr_idx==N_WORDS-1: ap_ready=1 for that cycle only, rd_idx<=N_WORDS-1, next state DRAIN.
  - in_V_empty_n=0: stall, no state change.
- DRAIN:
  - out_V_din = buf[rd_idx] (combinational mux).
  - out_V_write = out_V_full_n.
  - On a push: rd_idx--.
  - On the push with rd_idx==0: next state DONE.
  - out_V_full_n=0: stall, din held stable.
- DONE:
  - ap_done=1.
  - ap_continue=1 -> IDLE in the same cycle's edge.
  - ap_start may already be high in IDLE next cycle. Minimum gap between transactions is 1 IDLE cycle.
- ap_continue outside DONE: ignored.
- ap_idle=0 in all states except IDLE.
- No simultaneous read/write: FILL and DRAIN are exclusive.
- Latency, no stalls: 1 (IDLE) + N_WORDS (FILL) + N_WORDS (DRAIN) cycles to DONE.
  - First output word is pushed N_WORDS+1 cycles after ap_start is sampled.
- Data is passed bit-exact; no arithmetic on data.
- Index arithmetic is IDX_W-bit unsigned; no wrap occurs within legal parameters.

Optional Feature:
- Macro: SORT_COLLECT_CHECK_EN.
- Defined:
  - During FILL, each accepted word w[i] (i>0) is compared signed against w[i-1], held in a 32-bit register.
  - If w[i] > w[i-1], sort_err is set sticky.
  - sort_err is valid in DONE and cleared on the IDLE->FILL transition.
  - Equal words are not an error.
- Undefined:
  - No comparator or previous-word register is built.
  - sort_err tied to 0.

Decomposition:
- Shared package sort_pkg: DATA_W=32 and the state enum {IDLE, FILL, DRAIN, DONE}.
  - Include the cell-chain constants (N_CELLS) so the feeder, cells and collector agree on N_WORDS.
- One natural sub-module: sort_collect_buf.
  - N_WORDS x 32 register array, one synchronous write port, one combinational read port.
  - Keeps the FSM separate from storage.

Test Plan:
- Basic:
  - Stimulus: N_WORDS=8, input 70,60,50,40,30,20,10,0, FIFOs never stall.
  - Response: output 0,10,...,70; ap_ready pulses once on the 8th pop; ap_done rises 17 cycles after start; sort_err=0.
- Signed extremes:
  - Stimulus: input 0x7FFFFFFF, 5, 0, -1, 0x80000000, ...
  - Response: reversed bit-exact output; sort_err=0 with the macro defined.
- Backpressure:
  - Stimulus: in_V_empty_n toggles 1-0 each cycle; out_V_full_n held 0 for 3 cycles mid-DRAIN.
  - Response: no word lost or duplicated; out_V_din stable during the stall; order still reversed.
- Chaining:
  - Stimulus: ap_continue held 0 for 5 cycles in DONE, with a second transaction queued.
  - Response: ap_done stays 1 with no reads; after continue, the second transaction starts with correct data.
- Reset mid-operation:
  - Stimulus: ap_rst_n=0 for 1 cycle after 4 pops.
  - Response: next cycle ap_idle=1, no outputs driven; a following full transaction is correct.
- Check (SORT_COLLECT_CHECK_EN defined):
  - Stimulus: input 9,8,7,8,5,4,3,2.
  - Response: sort_err=1 in DONE; sort_err=0 after the next start with clean data.
